// File: rtl/count_seq_ctrl.sv
// Sequencer for a loadable up-counter: runs 0..limit in one-shot or free-run mode,
// with pause, stop/restart and a saturating wrap counter for free-run periods.
module count_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [WIDTH-1:0]  cfg_limit,
  input  logic              cfg_oneshot,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              tc,
  output logic [WRAP_W-1:0] wraps
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r, state_nx_s;
  logic [WIDTH-1:0]    count_r, count_nx_s;
  logic [WIDTH-1:0]    limit_r, limit_nx_s;
  logic                oneshot_r, oneshot_nx_s;
  logic [WRAP_W-1:0]   wraps_r, wraps_nx_s;
  logic                busy_r, done_r;
  logic                at_limit_s;

  assign at_limit_s = (count_r == limit_r);
  assign tc         = (state_r == ST_RUN) && !pause && at_limit_s;
  assign count      = count_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign wraps      = wraps_r;

  // State, counter, configuration and status flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      count_r   <= {WIDTH{1'b0}};
      wraps_r   <= {WRAP_W{1'b0}};
      limit_r   <= {WIDTH{1'b1}};
      oneshot_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      count_r   <= count_nx_s;
      wraps_r   <= wraps_nx_s;
      limit_r   <= limit_nx_s;
      oneshot_r <= oneshot_nx_s;
      busy_r    <= (state_nx_s == ST_RUN);
      done_r    <= (state_nx_s == ST_DONE);
    end
  end

  // Configuration is only writable outside RUN so a running sequence never changes shape.
  always_comb begin
    limit_nx_s   = limit_r;
    oneshot_nx_s = oneshot_r;
    if (cfg_we && (state_r != ST_RUN)) begin
      limit_nx_s   = cfg_limit;
      oneshot_nx_s = cfg_oneshot;
    end else begin
      limit_nx_s   = limit_r;
      oneshot_nx_s = oneshot_r;
    end
  end

  // Next-state and counter update: stop beats start beats counting.
  always_comb begin
    state_nx_s = state_r;
    count_nx_s = count_r;
    wraps_nx_s = wraps_r;
    if (stop) begin
      state_nx_s = ST_IDLE;
      count_nx_s = {WIDTH{1'b0}};
    end else if (start) begin
      state_nx_s = ST_RUN;
      count_nx_s = {WIDTH{1'b0}};
      wraps_nx_s = {WRAP_W{1'b0}};
    end else begin
      case (state_r)
        ST_RUN: begin
          if (pause) begin
            state_nx_s = ST_RUN;
          end else if (!at_limit_s) begin
            count_nx_s = count_r + WIDTH'(1);
          end else if (oneshot_r) begin
            state_nx_s = ST_DONE;
          end else begin
            count_nx_s = {WIDTH{1'b0}};
            if (wraps_r != {WRAP_W{1'b1}}) begin
              wraps_nx_s = wraps_r + WRAP_W'(1);
            end else begin
              wraps_nx_s = wraps_r;
            end
          end
        end
        ST_IDLE: state_nx_s = ST_IDLE;
        ST_DONE: state_nx_s = ST_DONE;
        default: begin
          state_nx_s = ST_IDLE;
          count_nx_s = {WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Scoreboard bench for count_seq_ctrl: directed test-plan sequences followed by
// random traffic, checked against a behavioural model of the sequencer rules.
module tb_count_seq_ctrl;

  logic       clk;
  logic       rst, cfg_we, cfg_oneshot, start, stop, pause;
  logic [3:0] cfg_limit;
  logic [3:0] count;
  logic       busy, done, tc;
  logic [7:0] wraps;

  count_seq_ctrl #(.WIDTH(4), .WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_limit(cfg_limit),
    .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop), .pause(pause),
    .count(count), .busy(busy), .done(done), .tc(tc), .wraps(wraps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       tc;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic [7:0] wraps;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: what the DUT should present during the current cycle.
  bit       mv = 1'b0;
  bit       m_busy, m_done, m_os;
  int       m_count, m_wraps, m_lim;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus: drive, record the expected view, advance the model.
  task automatic drive(input logic r, input logic we, input logic [3:0] lim, input logic os,
                       input logic st, input logic sp, input logic pa);
    exp_t e;
    bit   was_busy;
    @(negedge clk);
    rst = r; cfg_we = we; cfg_limit = lim; cfg_oneshot = os;
    start = st; stop = sp; pause = pa;
    if (mv) begin
      e.tc    = m_busy && !pa && (m_count == m_lim);
      e.count = 4'(m_count);
      e.busy  = m_busy;
      e.done  = m_done;
      e.wraps = 8'(m_wraps);
      q.push_back(e);
    end
    if (r) begin
      m_busy = 1'b0; m_done = 1'b0; m_count = 0; m_wraps = 0; m_lim = 15; m_os = 1'b0;
      mv = 1'b1;
    end else begin
      was_busy = m_busy;
      if (sp) begin
        m_busy = 1'b0; m_done = 1'b0; m_count = 0;
      end else if (st) begin
        m_busy = 1'b1; m_done = 1'b0; m_count = 0; m_wraps = 0;
      end else if (m_busy && !pa) begin
        if (m_count < m_lim) m_count = m_count + 1;
        else if (m_os) begin m_busy = 1'b0; m_done = 1'b1; end
        else begin m_count = 0; m_wraps = (m_wraps < 255) ? m_wraps + 1 : 255; end
      end
      if (we && !was_busy) begin
        m_lim = int'(lim); m_os = os;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares the DUT against the oldest expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare("tc",    32'(tc),    32'(e.tc));
        compare("count", 32'(count), 32'(e.count));
        compare("busy",  32'(busy),  32'(e.busy));
        compare("done",  32'(done),  32'(e.done));
        compare("wraps", 32'(wraps), 32'(e.wraps));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    int pcnt;
    int guard;
    rst = 1'b1; cfg_we = 1'b0; cfg_limit = 4'd0; cfg_oneshot = 1'b0;
    start = 1'b0; stop = 1'b0; pause = 1'b0;

    // Reset defaults, then default config: free-run L=15.
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(20);

    // One-shot L=5, then hold in DONE.
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(18);

    // Free-run L=3 with config+start together, 2-cycle pause at count 3.
    drive(1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    pcnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (m_busy && m_count == 3 && pcnt < 2) begin
        pcnt++;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    // Config lockout in RUN (L=7), then restart at count 4.
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);
    guard = 0;
    while (m_count != 4 && guard < 20) begin
      idle(1);
      guard++;
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);

    // Stop beats start; then L=0 one-shot and L=0 free-run through saturation.
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    drive(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(300);

    // Mid-run reset with other inputs active.
    drive(1'b1, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(63, 0) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(7, 0) == 0) ? 1'b1 : 1'b0,
            4'($urandom_range(15, 0)),
            1'($urandom_range(1, 0)),
            ($urandom_range(15, 0) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(31, 0) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(3, 0) == 0) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    #5;
    compare("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
